// File: rtl/esm_dep_scoreboard.sv
// esm_dep_scoreboard: register RAW dependency scoreboard between decode and execute.
// One buffer entry per accepted instruction; producers are found through a
// last-writer table and tracked as a per-entry dependency bit vector.
// Optional build macro ESM_WAW_TRACK_EN adds WAW and WAR ordering.
module esm_dep_scoreboard #(
  parameter int INSTR_W = 32,
  parameter int REGNUM  = 32,
  parameter int BS      = 16,
  localparam int RAB    = $clog2(REGNUM),
  localparam int BSB    = $clog2(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               alu_src,
  input  logic               reg_write,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  output logic [BSB-1:0]     alloc_index,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [BSB-1:0]     issue_index,
  input  logic               complete_valid,
  input  logic [BSB-1:0]     complete_index,
  output logic [BSB:0]       occupancy,
  output logic               empty,
  output logic               full,
  output logic               err
);

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_ISSUED} ent_state_e;

  ent_state_e     state_q [BS];
  ent_state_e     state_d [BS];
  logic [BS-1:0]  dep_q [BS];
  logic [BS-1:0]  dep_d [BS];
  logic [BSB-1:0] lw_idx_q [REGNUM];
  logic [BSB-1:0] lw_idx_d [REGNUM];
  logic [REGNUM-1:0] lw_vld_q, lw_vld_d;
  logic [BSB:0]   occ_q, occ_d;
  logic           err_q, err_d;
  logic           hold_q, hold_d;
  logic [BSB-1:0] hold_idx_q, hold_idx_d;
`ifdef ESM_WAW_TRACK_EN
  logic [RAB-1:0] src1_q [BS];
  logic [RAB-1:0] src1_d [BS];
  logic [RAB-1:0] src2_q [BS];
  logic [RAB-1:0] src2_d [BS];
`endif

  logic [BSB-1:0] free_idx, rdy_idx;
  logic           rdy_found;
  logic           alloc_fire, issue_fire, cmp_fire;
  logic [RAB-1:0] rs1, rs2, rd;
  logic [BS-1:0]  dep_new;
  logic           unused_bits;

  assign unused_bits = ^{instr_in[INSTR_W-1:25], instr_in[14:12], instr_in[6:0]};

  // Priority search: lowest-index FREE entry and lowest-index READY entry.
  always_comb begin
    free_idx  = '0;
    rdy_idx   = '0;
    rdy_found = 1'b0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) free_idx = BSB'(i);
      if (state_q[i] == ST_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = BSB'(i);
      end
    end
  end

  assign full        = (occ_q == (BSB+1)'(BS));
  assign empty       = (occ_q == '0);
  assign occupancy   = occ_q;
  assign alloc_ready = ~full;
  assign alloc_index = free_idx;
  assign err         = err_q;
  // A stalled offer keeps its index even if a lower entry becomes ready meanwhile.
  assign issue_valid = hold_q | rdy_found;
  assign issue_index = hold_q ? hold_idx_q : rdy_idx;

  assign alloc_fire = alloc_valid & alloc_ready;
  assign issue_fire = issue_valid & issue_ready;
  assign cmp_fire   = complete_valid & (state_q[complete_index] == ST_ISSUED);

  // Dependency vector of the instruction being allocated, minus a producer completing now.
  always_comb begin
    rs1     = RAB'(instr_in[19:15]);
    rs2     = alu_src ? RAB'(instr_in[24:20]) : '0;
    rd      = reg_write ? RAB'(instr_in[11:7]) : '0;
    dep_new = '0;
    if (rs1 != '0 && lw_vld_q[rs1]) dep_new[lw_idx_q[rs1]] = 1'b1;
    if (rs2 != '0 && lw_vld_q[rs2]) dep_new[lw_idx_q[rs2]] = 1'b1;
`ifdef ESM_WAW_TRACK_EN
    if (rd != '0 && lw_vld_q[rd]) dep_new[lw_idx_q[rd]] = 1'b1;
    for (int j = 0; j < BS; j++) begin
      if (rd != '0 && (state_q[j] == ST_WAIT || state_q[j] == ST_READY) &&
          (src1_q[j] == rd || src2_q[j] == rd))
        dep_new[j] = 1'b1;
    end
`endif
    if (cmp_fire) dep_new[complete_index] = 1'b0;
  end

  // Next state of entries, last-writer table, occupancy, error flag and issue hold.
  always_comb begin
    state_d    = state_q;
    dep_d      = dep_q;
    lw_idx_d   = lw_idx_q;
    lw_vld_d   = lw_vld_q;
    occ_d      = occ_q;
    err_d      = err_q | (complete_valid & ~cmp_fire);
    hold_d     = issue_valid & ~issue_ready;
    hold_idx_d = issue_index;
`ifdef ESM_WAW_TRACK_EN
    src1_d     = src1_q;
    src2_d     = src2_q;
`endif
    if (cmp_fire) begin
      for (int j = 0; j < BS; j++) dep_d[j][complete_index] = 1'b0;
      state_d[complete_index] = ST_FREE;
      dep_d[complete_index]   = '0;
      for (int r = 0; r < REGNUM; r++) begin
        if (lw_vld_q[r] && lw_idx_q[r] == complete_index) lw_vld_d[r] = 1'b0;
      end
    end
    if (issue_fire) state_d[issue_index] = ST_ISSUED;
    if (alloc_fire) begin
      state_d[free_idx] = (dep_new == '0) ? ST_READY : ST_WAIT;
      dep_d[free_idx]   = dep_new;
`ifdef ESM_WAW_TRACK_EN
      src1_d[free_idx]  = rs1;
      src2_d[free_idx]  = rs2;
`endif
      if (rd != '0) begin
        lw_vld_d[rd] = 1'b1;
        lw_idx_d[rd] = free_idx;
      end
    end
    for (int i = 0; i < BS; i++) begin
      if (state_d[i] == ST_WAIT && dep_d[i] == '0) state_d[i] = ST_READY;
    end
    case ({alloc_fire, cmp_fire})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= ST_FREE;
        dep_q[i]   <= '0;
      end
      lw_vld_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dep_q    <= dep_d;
      lw_vld_q <= lw_vld_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  // Index payloads: only meaningful while their valid/state bits are set.
  always_ff @(posedge clk) begin
    lw_idx_q   <= lw_idx_d;
    hold_idx_q <= hold_idx_d;
`ifdef ESM_WAW_TRACK_EN
    src1_q     <= src1_d;
    src2_q     <= src2_d;
`endif
  end

endmodule
